io_port_bank: RTL and testbench
===============================

# io_port_bank

Parametrised multi-channel I/O port bank that succeeds the single in/out port pair on the datapath bus. `in Ra` pops a word from a per-channel input FIFO filled by external strobes. `out Ra` posts a word to a per-channel output register with a valid/ack handshake. The bank sits beside the register file on the datapath bus and is driven by InPort_read and OutPort_write from the control sequence. The channel is selected from IR low bits.

## Interface
- DATA_W, 32, width of bus and every channel
- NUM_CH, 4, number of input and number of output channels (≥1)
- IN_DEPTH, 4, input FIFO depth per channel (power of 2, ≥2)
- CH_W, max(1,clog2(NUM_CH)), derived, not overridden

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  reset; asynchronous, active-low
- ch_sel  in  CH_W  channel for current read/write; values ≥NUM_CH are ignored (no effect, read returns 0)
- bus_in  in  DATA_W  datapath bus, source for out writes
- outport_write  in  1  write bus_in to output channel ch_sel
- inport_read  in  1  pop input channel ch_sel
- inport_data  out  DATA_W  head word of channel ch_sel (combinational from registered storage)
- in_empty  out  NUM_CH  per-channel FIFO empty
- ext_in_data  in  NUM_CH*DATA_W  external input words, channel i at [i*DATA_W +: DATA_W]
- ext_in_strobe  in  NUM_CH  push request per channel
- ext_in_full  out  NUM_CH  per-channel FIFO full (backpressure)
- ext_out_data  out  NUM_CH*DATA_W  latched output words
- ext_out_valid  out  NUM_CH  word pending per channel
- ext_out_ack  in  NUM_CH  consumer accepts pending word
- overrun  out  NUM_CH  sticky: strobe dropped on full FIFO
- out_drop  out  NUM_CH  sticky: write dropped on busy output
- status_clr  in  1  synchronous clear of overrun and out_drop

## Operation
- Input FIFO per channel: write pointer, read pointer, and count (width clog2(IN_DEPTH)+1). Pointers wrap modulo IN_DEPTH.
- Push: ext_in_strobe[i] with count<IN_DEPTH stores the word.
- Push when full is dropped and sets overrun[i]. Exception: if a pop of the same channel occurs in the same cycle, the push is accepted and count is unchanged.
- Pop: inport_read with ch_sel valid and not empty advances the read pointer. inport_data shows the head in the same cycle.
- Pop when empty: no state change, inport_data=0.
- Simultaneous push and pop on an empty FIFO: the pop is ignored (inport_data=0) and the push is accepted.
- Output channel FSM per channel with states OUT_IDLE and OUT_PEND:
  - OUT_IDLE + write → latch bus_in, go to OUT_PEND.
  - OUT_PEND + ack → OUT_IDLE.
  - OUT_PEND + ack + write same cycle → latch the new word, stay in OUT_PEND (back-to-back).
  - OUT_PEND + write without ack → write dropped, out_drop set, data unchanged.
- ext_out_valid = (state==OUT_PEND).
- ext_out_data holds the last accepted word indefinitely (port-latch semantics), including in OUT_IDLE.
- Ack in OUT_IDLE is ignored.
- status_clr clears the sticky flags. A new error in the same cycle wins (the flag stays set).

## Timing
- Reset (clr low, asynchronous): all FIFOs empty, pointers 0, in_empty all 1, ext_in_full 0, ext_out_data 0, ext_out_valid 0, FSMs OUT_IDLE, overrun 0, out_drop 0, inport_data 0.
- Reset mid-transfer discards FIFO contents and pending output words immediately.
- Strobe at edge N → in_empty[i] low after edge N, so the word is readable in cycle N+1.
- inport_read: zero-latency data, pointer update at the sampling edge.
- Write at edge N → ext_out_valid high and data stable after edge N.
- Ack sampled at edge M → valid low after M.
- Sustained throughput: one word per cycle per channel in each direction.

## Structure
- Package io_port_pkg holds:
  - default DATA_W, NUM_CH, IN_DEPTH constants
  - out_state_t enum {OUT_IDLE, OUT_PEND}
- Sub-module io_in_fifo (DATA_W, IN_DEPTH), generated NUM_CH times. It exposes push, pop, head, empty, full, and overflow pulse.
- Output FSMs and the read mux live in io_port_bank.

## Test plan
- Reset values: assert clr low mid-cycle → all outputs take their reset values asynchronously, without waiting for a clock edge.
- FIFO order on channel 2: push 0x11, 0x22, 0x33, then read ×3 with ch_sel=2 → inport_data 0x11, 0x22, 0x33. in_empty[2]=1 afterwards; a fourth read returns 0.
- Full and overrun on channel 0 (IN_DEPTH=4): push 5 words → 5th dropped, overrun[0]=1, ext_in_full[0]=1. Then push+pop in the same cycle → accepted, FIFO stays full, head advances.
- Out handshake on channel 1: write 0xCAFE0001 → valid[1]=1 next cycle. Second write without ack → out_drop[1]=1, data still 0xCAFE0001. Ack+write 0x0002 same cycle → valid stays 1, data 0x0002. Ack → valid 0, data held at 0x0002.
- Channel isolation: concurrent strobes on all channels and writes to channel 3 → no cross-channel changes. ch_sel=NUM_CH (with NUM_CH not a power of 2, e.g. 3) → no state change, read returns 0.
- status_clr: flags set, then status_clr → flags 0. status_clr coincident with a new overrun → flag stays 1.

Source files
------------

// File: rtl/io_port_pkg.sv
// io_port_pkg: shared constants and types for the multi-channel I/O port bank.
//   DEF_DATA_W   - default bus / channel word width
//   DEF_NUM_CH   - default number of input and output channels
//   DEF_IN_DEPTH - default input FIFO depth per channel (power of 2)
//   out_state_t  - output channel handshake state
package io_port_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_NUM_CH   = 4;
    localparam int unsigned DEF_IN_DEPTH = 4;

    typedef enum logic [0:0] {
        OUT_IDLE = 1'b0,
        OUT_PEND = 1'b1
    } out_state_t;

endpackage

// File: rtl/io_in_fifo.sv
// io_in_fifo: single-channel input FIFO for the port bank.
// Ports:
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset (empties the FIFO)
//   push_i      external strobe, stores data_i when room is available
//   data_i      word to push
//   pop_i       pop request (ignored when empty)
//   head_o      oldest stored word, 0 when empty
//   empty_o     no words stored
//   full_o      IN_DEPTH words stored
//   overflow_o  one-cycle pulse: push dropped because the FIFO was full
module io_in_fifo
    import io_port_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned IN_DEPTH = DEF_IN_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              overflow_o
);

    localparam int unsigned PtrW = $clog2(IN_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_W-1:0] mem_q [IN_DEPTH];
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [CntW-1:0]   count_q, count_d;

    logic pop_ok;
    logic push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(IN_DEPTH));

    // A pop on an empty FIFO is ignored even when a push arrives the same cycle.
    assign pop_ok  = pop_i & ~empty_o;
    // A pop frees the slot this cycle, so a push on a full FIFO still fits.
    assign push_ok = push_i & (~full_o | pop_ok);

    assign overflow_o = push_i & full_o & ~pop_ok;

    assign head_o = empty_o ? '0 : mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        // Pointers wrap naturally since IN_DEPTH is a power of 2.
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: head_o is gated by empty_o.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: multi-channel I/O port bank on the datapath bus.
// "in Ra" pops a word from a per-channel input FIFO filled by external strobes;
// "out Ra" posts a word to a per-channel output latch with a valid/ack handshake.
// Ports:
//   clk            rising-edge clock
//   clr            asynchronous active-low reset
//   ch_sel         channel for the current read/write; out-of-range values do nothing
//   bus_in         datapath bus, source for output writes
//   outport_write  write bus_in to output channel ch_sel
//   inport_read    pop input channel ch_sel
//   inport_data    head word of channel ch_sel (0 when empty or out of range)
//   in_empty       per-channel input FIFO empty
//   ext_in_data    external input words, channel i at [i*DATA_W +: DATA_W]
//   ext_in_strobe  per-channel push request
//   ext_in_full    per-channel input FIFO full
//   ext_out_data   per-channel latched output word
//   ext_out_valid  per-channel word pending
//   ext_out_ack    per-channel consumer accept
//   overrun        sticky: strobe dropped on a full FIFO
//   out_drop       sticky: write dropped on a busy output
//   status_clr     synchronous clear of overrun and out_drop
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_CH   = DEF_NUM_CH,
    parameter int unsigned IN_DEPTH = DEF_IN_DEPTH,
    // Derived; do not override.
    parameter int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [CH_W-1:0]          ch_sel,
    input  logic [DATA_W-1:0]        bus_in,
    input  logic                     outport_write,
    input  logic                     inport_read,
    output logic [DATA_W-1:0]        inport_data,
    output logic [NUM_CH-1:0]        in_empty,
    input  logic [NUM_CH*DATA_W-1:0] ext_in_data,
    input  logic [NUM_CH-1:0]        ext_in_strobe,
    output logic [NUM_CH-1:0]        ext_in_full,
    output logic [NUM_CH*DATA_W-1:0] ext_out_data,
    output logic [NUM_CH-1:0]        ext_out_valid,
    input  logic [NUM_CH-1:0]        ext_out_ack,
    output logic [NUM_CH-1:0]        overrun,
    output logic [NUM_CH-1:0]        out_drop,
    input  logic                     status_clr
);

    logic [DATA_W-1:0] head [NUM_CH];
    logic [NUM_CH-1:0] pop_req;
    logic [NUM_CH-1:0] wr_req;
    logic [NUM_CH-1:0] ovf_evt;
    logic [NUM_CH-1:0] drop_evt;

    out_state_t        out_state_q [NUM_CH];
    out_state_t        out_state_d [NUM_CH];
    logic [DATA_W-1:0] out_data_q  [NUM_CH];
    logic [DATA_W-1:0] out_data_d  [NUM_CH];

    logic [NUM_CH-1:0] overrun_q, overrun_d;
    logic [NUM_CH-1:0] out_drop_q, out_drop_d;

    // ---------------------------------------------------------------------
    // Per-channel input FIFOs and request decode
    // ---------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range ch_sel never matches any channel, so it has no effect.
        assign pop_req[i] = inport_read   & (ch_sel == CH_W'(i));
        assign wr_req[i]  = outport_write & (ch_sel == CH_W'(i));

        io_in_fifo #(
            .DATA_W   (DATA_W),
            .IN_DEPTH (IN_DEPTH)
        ) u_fifo (
            .clk_i      (clk),
            .rst_ni     (clr),
            .push_i     (ext_in_strobe[i]),
            .data_i     (ext_in_data[i*DATA_W +: DATA_W]),
            .pop_i      (pop_req[i]),
            .head_o     (head[i]),
            .empty_o    (in_empty[i]),
            .full_o     (ext_in_full[i]),
            .overflow_o (ovf_evt[i])
        );

        assign ext_out_data[i*DATA_W +: DATA_W] = out_data_q[i];
        assign ext_out_valid[i]                 = (out_state_q[i] == OUT_PEND);
    end

    // ---------------------------------------------------------------------
    // Read mux: zero-latency view of the selected channel's head
    // ---------------------------------------------------------------------
    always_comb begin
        inport_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                inport_data = head[i];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output channel handshake FSMs
    // ---------------------------------------------------------------------
    always_comb begin
        drop_evt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            out_state_d[i] = out_state_q[i];
            out_data_d[i]  = out_data_q[i];
            case (out_state_q[i])
                OUT_IDLE: begin
                    // Ack with nothing pending is ignored.
                    if (wr_req[i]) begin
                        out_data_d[i]  = bus_in;
                        out_state_d[i] = OUT_PEND;
                    end
                end
                OUT_PEND: begin
                    if (ext_out_ack[i]) begin
                        // Ack frees the latch this cycle, allowing back-to-back writes.
                        if (wr_req[i]) begin
                            out_data_d[i] = bus_in;
                        end else begin
                            out_state_d[i] = OUT_IDLE;
                        end
                    end else if (wr_req[i]) begin
                        drop_evt[i] = 1'b1;
                    end
                end
                default: out_state_d[i] = OUT_IDLE;
            endcase
        end
    end

    // New errors win over a coincident status_clr.
    assign overrun_d  = (status_clr ? '0 : overrun_q)  | ovf_evt;
    assign out_drop_d = (status_clr ? '0 : out_drop_q) | drop_evt;

    assign overrun  = overrun_q;
    assign out_drop = out_drop_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                out_state_q[i] <= OUT_IDLE;
                out_data_q[i]  <= '0;
            end
            overrun_q  <= '0;
            out_drop_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                out_state_q[i] <= out_state_d[i];
                out_data_q[i]  <= out_data_d[i];
            end
            overrun_q  <= overrun_d;
            out_drop_q <= out_drop_d;
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed and randomized check of io_port_bank against a
// queue-based behavioural model. NUM_CH=3 so that ch_sel=3 is out of range.
module tb_io_port_bank;

    localparam int DW  = 32;
    localparam int NC  = 3;
    localparam int DEP = 4;
    localparam int CW  = 2;

    logic              clk;
    logic              clr;
    logic [CW-1:0]     ch_sel;
    logic [DW-1:0]     bus_in;
    logic              outport_write;
    logic              inport_read;
    logic [DW-1:0]     inport_data;
    logic [NC-1:0]     in_empty;
    logic [NC*DW-1:0]  ext_in_data;
    logic [NC-1:0]     ext_in_strobe;
    logic [NC-1:0]     ext_in_full;
    logic [NC*DW-1:0]  ext_out_data;
    logic [NC-1:0]     ext_out_valid;
    logic [NC-1:0]     ext_out_ack;
    logic [NC-1:0]     overrun;
    logic [NC-1:0]     out_drop;
    logic              status_clr;

    io_port_bank #(
        .DATA_W   (DW),
        .NUM_CH   (NC),
        .IN_DEPTH (DEP)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .ch_sel        (ch_sel),
        .bus_in        (bus_in),
        .outport_write (outport_write),
        .inport_read   (inport_read),
        .inport_data   (inport_data),
        .in_empty      (in_empty),
        .ext_in_data   (ext_in_data),
        .ext_in_strobe (ext_in_strobe),
        .ext_in_full   (ext_in_full),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ack   (ext_out_ack),
        .overrun       (overrun),
        .out_drop      (out_drop),
        .status_clr    (status_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: one queue per input channel, a pending flag and a
    // latched word per output channel, and the two sticky flag vectors.
    logic [DW-1:0] fq [NC][$];
    logic          m_pend  [NC];
    logic [DW-1:0] m_odata [NC];
    logic [NC-1:0] m_ovr;
    logic [NC-1:0] m_drp;

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            fq[i].delete();
            m_pend[i]  = 1'b0;
            m_odata[i] = '0;
        end
        m_ovr = '0;
        m_drp = '0;
    endtask

    task automatic check_model();
        logic [DW-1:0]    e_rd;
        logic [NC-1:0]    e_emp, e_full, e_val;
        logic [NC*DW-1:0] e_od;
        e_rd = '0;
        if (int'(ch_sel) < NC && fq[int'(ch_sel)].size() > 0) e_rd = fq[int'(ch_sel)][0];
        for (int i = 0; i < NC; i++) begin
            e_emp[i]            = (fq[i].size() == 0);
            e_full[i]           = (fq[i].size() == DEP);
            e_val[i]            = m_pend[i];
            e_od[i*DW +: DW]    = m_odata[i];
        end
        check("inport_data", inport_data, e_rd);
        check("in_empty", in_empty, e_emp);
        check("ext_in_full", ext_in_full, e_full);
        check("ext_out_data", ext_out_data, e_od);
        check("ext_out_valid", ext_out_valid, e_val);
        check("overrun", overrun, m_ovr);
        check("out_drop", out_drop, m_drp);
    endtask

    task automatic model_update();
        logic [NC-1:0] new_ovr, new_drp;
        new_ovr = '0;
        new_drp = '0;
        for (int i = 0; i < NC; i++) begin
            int  sz;
            bit  pop, wr;
            sz  = fq[i].size();
            pop = inport_read && int'(ch_sel) == i && sz > 0;
            wr  = outport_write && int'(ch_sel) == i;
            if (pop) void'(fq[i].pop_front());
            if (ext_in_strobe[i]) begin
                if (sz < DEP || pop) fq[i].push_back(ext_in_data[i*DW +: DW]);
                else new_ovr[i] = 1'b1;
            end
            if (!m_pend[i]) begin
                if (wr) begin
                    m_odata[i] = bus_in;
                    m_pend[i]  = 1'b1;
                end
            end else if (ext_out_ack[i]) begin
                if (wr) m_odata[i] = bus_in;
                else m_pend[i] = 1'b0;
            end else if (wr) begin
                new_drp[i] = 1'b1;
            end
        end
        m_ovr = (status_clr ? '0 : m_ovr) | new_ovr;
        m_drp = (status_clr ? '0 : m_drp) | new_drp;
    endtask

    // Compare against the model just before the edge, then advance one cycle.
    task automatic tick();
        check_model();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        #3;
        tick();
    endtask

    task automatic idle();
        ch_sel        = '0;
        bus_in        = '0;
        outport_write = 1'b0;
        inport_read   = 1'b0;
        ext_in_data   = '0;
        ext_in_strobe = '0;
        ext_out_ack   = '0;
        status_clr    = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_empty"}, in_empty, {NC{1'b1}});
        check({tag, "_in_full"}, ext_in_full, '0);
        check({tag, "_out_data"}, ext_out_data, '0);
        check({tag, "_out_valid"}, ext_out_valid, '0);
        check({tag, "_overrun"}, overrun, '0);
        check({tag, "_out_drop"}, out_drop, '0);
        check({tag, "_inport_data"}, inport_data, '0);
    endtask

    task automatic random_phase(input int n, input int strobe_pct, input int read_pct);
        for (int k = 0; k < n; k++) begin
            idle();
            for (int c = 0; c < NC; c++) begin
                ext_in_strobe[c]      = ($urandom_range(0, 99) < strobe_pct);
                ext_in_data[c*DW +: DW] = $urandom;
                ext_out_ack[c]        = ($urandom_range(0, 99) < 40);
            end
            ch_sel        = CW'($urandom_range(0, 3));
            inport_read   = ($urandom_range(0, 99) < read_pct);
            outport_write = ($urandom_range(0, 99) < 40);
            bus_in        = $urandom;
            status_clr    = ($urandom_range(0, 99) < 5);
            cyc();
        end
    endtask

    initial begin
        clr = 1'b0;
        idle();
        model_reset();
        #3;
        check_reset_values("por");
        @(posedge clk);
        #1;
        clr = 1'b1;
        cyc();

        // FIFO order on channel 2.
        ext_in_strobe = 3'b100; ext_in_data[2*DW +: DW] = 32'h11; cyc();
        ext_in_data[2*DW +: DW] = 32'h22; cyc();
        ext_in_data[2*DW +: DW] = 32'h33; cyc();
        idle();
        ch_sel = 2'd2; inport_read = 1'b1;
        #3; check("fifo_rd0", inport_data, 32'h11); tick();
        #3; check("fifo_rd1", inport_data, 32'h22); tick();
        #3; check("fifo_rd2", inport_data, 32'h33); tick();
        #3; check("fifo_rd3_empty", inport_data, 32'h0);
        check("fifo_empty2", in_empty[2], 1'b1); tick();

        // Full and overrun on channel 0.
        idle();
        for (int k = 0; k < 5; k++) begin
            ext_in_strobe = 3'b001;
            ext_in_data[0 +: DW] = 32'hA0 + k;
            cyc();
        end
        idle();
        #3;
        check("ovr0_set", overrun[0], 1'b1);
        check("full0_set", ext_in_full[0], 1'b1);
        tick();
        ext_in_strobe = 3'b001; ext_in_data[0 +: DW] = 32'hA5;
        ch_sel = 2'd0; inport_read = 1'b1;
        #3; check("pushpop_head", inport_data, 32'hA0); tick();
        idle();
        #3;
        check("pushpop_full", ext_in_full[0], 1'b1);
        check("pushpop_next", inport_data, 32'hA1);
        tick();

        // Output handshake on channel 1.
        ch_sel = 2'd1; outport_write = 1'b1; bus_in = 32'hCAFE0001; cyc();
        bus_in = 32'h0BAD0BAD;
        #3;
        check("out_valid1", ext_out_valid[1], 1'b1);
        check("out_data1", ext_out_data[1*DW +: DW], 32'hCAFE0001);
        tick();
        ext_out_ack = 3'b010; bus_in = 32'h00000002;
        #3;
        check("out_drop1", out_drop[1], 1'b1);
        check("out_hold1", ext_out_data[1*DW +: DW], 32'hCAFE0001);
        tick();
        outport_write = 1'b0;
        #3;
        check("b2b_valid1", ext_out_valid[1], 1'b1);
        check("b2b_data1", ext_out_data[1*DW +: DW], 32'h00000002);
        tick();
        idle();
        #3;
        check("ack_valid1", ext_out_valid[1], 1'b0);
        check("ack_hold1", ext_out_data[1*DW +: DW], 32'h00000002);
        tick();

        // Channel isolation and out-of-range select.
        ext_in_strobe = 3'b111;
        ext_in_data   = {32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
        ch_sel = 2'd2; outport_write = 1'b1; bus_in = 32'h5A5A0002;
        cyc();
        idle();
        ch_sel = 2'd3; inport_read = 1'b1; outport_write = 1'b1; bus_in = 32'hDEADBEEF;
        #3; check("sel_oob_rd", inport_data, 32'h0); tick();
        idle();
        cyc();

        // Sticky flag clear, and clear losing to a coincident new overrun.
        status_clr = 1'b1; cyc();
        idle();
        #3;
        check("clr_ovr", overrun, '0);
        check("clr_drop", out_drop, '0);
        tick();
        status_clr = 1'b1; ext_in_strobe = 3'b001; ext_in_data[0 +: DW] = 32'hEE;
        cyc();
        idle();
        #3; check("clr_vs_new_ovr", overrun[0], 1'b1); tick();

        // Randomized traffic: fill-heavy, then drain-heavy, then balanced.
        random_phase(600, 60, 25);
        random_phase(600, 15, 90);
        random_phase(600, 40, 60);

        // Asynchronous reset between edges.
        random_phase(20, 80, 10);
        idle();
        #2;
        clr = 1'b0;
        #1;
        check_reset_values("async");
        model_reset();
        @(posedge clk);
        #1;
        clr = 1'b1;
        random_phase(300, 40, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
